mem_port_b_streamer: RTL and testbench
======================================

// Module: mem_port_b_streamer
// PURPOSE
// - Sole consumer of port B of the DPSSRAM behind the AXI4-Lite register bank (mem_adr_i/mem_r1_rd_i/mem_r1_dat_o).
// - Software fills the RAM over AXI4-Lite. This block then reads a programmed window of it on port B.
// - It emits the words as a valid/ready byte stream, one-shot or looping, at one word per clock when not backpressured.
// PARAMETERS
// - G_ADDR_WIDTH  10  RAM word address width; must equal the port-B address width.
// - G_DATA_WIDTH   8  RAM word width, which is also the stream width.
// - G_FIFO_DEPTH   2  Output buffer entries; minimum 2, power of two.
// PORTS
// - aclk        in   1             Single clock; also clocks RAM port B.
// - areset      in   1             Synchronous, active-high reset.
// - start_i     in   1             Pulse: latch base_i/len_i/loop_i and begin. Ignored while busy_o=1.
// - stop_i      in   1             Pulse: stop issuing reads and drain what is in flight.
// - base_i      in   G_ADDR_WIDTH  First word address of the window.
// - len_i       in   G_ADDR_WIDTH+1  Window length in words, 0..2**G_ADDR_WIDTH.
// - loop_i      in   1             1 = restart at base after the last word, until stop_i.
// - busy_o      out  1             High from the accepted start until the cycle done_o is asserted.
// - done_o      out  1             One-cycle pulse at end of run.
// - mem_adr_o   out  G_ADDR_WIDTH  Connects to mem_adr_i.
// - mem_rd_o    out  1             Connects to mem_r1_rd_i.
// - mem_dat_i   in   G_DATA_WIDTH  Connects to mem_r1_dat_o; valid 1 cycle after mem_rd_o.
// - tvalid_o    out  1             Stream valid.
// - tready_i    in   1             Stream ready.
// - tdata_o     out  G_DATA_WIDTH  Stream data.
// - tlast_o     out  1             Marks the last word of each pass.
// BEHAVIOUR
// - Reset values: busy_o, done_o, mem_rd_o, tvalid_o, tlast_o = 0; mem_adr_o, tdata_o = 0. FIFO and counters cleared.
// - FSM states: IDLE, RUN, DRAIN.
//   - IDLE + start_i + len_i!=0 -> RUN. Latch base, len and loop; idx=0; busy_o=1 from the next cycle.
//   - IDLE + start_i + len_i==0 -> done_o pulse next cycle; stay IDLE; busy_o stays 0.
//   - RUN: when a read issues, mem_rd_o=1 and mem_adr_o = (base+idx) mod 2**G_ADDR_WIDTH. The address wraps at the top of the RAM.
//     - Then idx++.
//     - On issuing idx==len-1: if loop, set idx=0 and stay in RUN; else go to DRAIN.
//   - RUN + stop_i -> DRAIN. The read issued in the same cycle completes; no new reads are issued.
//   - DRAIN: once the FIFO is empty, no read is in flight and no word is held -> done_o=1 for 1 cycle, busy_o=0, go to IDLE.
//   - start_i and stop_i in the same cycle from IDLE: start wins. stop_i in IDLE or DRAIN is ignored.
// - Read issue rule: issue only if (fifo_count + inflight - pop) < G_FIFO_DEPTH.
//   - pop = tvalid_o & tready_i.
//   - The FIFO can never overflow.
//   - With tready_i held high, the stream sustains 1 word/clock.
// - Capture: one cycle after mem_rd_o, push mem_dat_i into the FIFO, tagged with tlast = (issued idx == len-1).
// - Latency: start_i to first mem_rd_o is 1 cycle. mem_rd_o to tvalid_o is 2 cycles (RAM latency + FIFO register).
// - Stream rules:
//   - tdata_o/tlast_o are stable while tvalid_o=1 and tready_i=0.
//   - tvalid_o never drops without a pop.
//   - FIFO outputs are registered.
// - Port A writes that collide with a port-B read return undefined data. Keeping them apart is software's job; the block does not arbitrate.
// - Reset mid-run: all state returns to reset values next cycle, FIFO contents are discarded, no done_o is produced.
// - len_i = 2**G_ADDR_WIDTH reads the whole RAM once, starting at base.
// STRUCTURE
// - Package mem_port_b_streamer_pkg:
//   - typedef enum {ST_IDLE, ST_RUN, ST_DRAIN} stream_state_t.
//   - FIFO depth localparams and the count width function.
// - Sub-module mem_port_b_fifo: synchronous show-ahead FIFO, width G_DATA_WIDTH+1 (data+last).
//   - Ports: push, pop, count, empty, full.
// - Top level: FSM, index/address counter, inflight flag and issue-credit logic.
// TESTING
// - One-shot: base=0x010, len=4, loop=0, RAM[0x10..0x13]=A0..A3, tready=1.
//   -> tdata A0,A1,A2,A3 on consecutive cycles; tlast only on A3; done_o 1 cycle after A3 pops; busy_o low.
// - Address wrap: base=0x3FE, len=4.
//   -> mem_adr_o 0x3FE,0x3FF,0x000,0x001; stream order matches.
// - Backpressure: len=8, tready toggled 1/0 every cycle.
//   -> all 8 words delivered in order, none lost or duplicated; FIFO never exceeds G_FIFO_DEPTH; data stable while stalled.
// - Loop and stop: base=0, len=3, loop=1; stop_i after 7 words popped.
//   -> sequence D0,D1,D2,D0,D1,D2,D0,... with tlast every 3rd word; in-flight words delivered after stop, then done_o; no further mem_rd_o.
// - Edge starts:
//   - len=0 -> done_o next cycle, no mem_rd_o, no tvalid_o.
//   - start_i while busy -> ignored; latched parameters unchanged.
// - Reset mid-run: assert areset with 2 words buffered.
//   -> next cycle tvalid_o=0, busy_o=0, mem_rd_o=0, done_o never pulses; a fresh start runs correctly.

Source files
------------

// File: rtl/mem_port_b_streamer_pkg.sv
// Shared types and sizing helpers for the RAM port-B streamer.
package mem_port_b_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } stream_state_t;

    localparam int C_FIFO_DEPTH_DEF = 2;
    localparam int C_FIFO_DEPTH_MIN = 2;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mem_port_b_streamer_if.sv
// RAM port-B read bus plus the outgoing valid/ready byte stream.
interface mem_port_b_streamer_if #(
    parameter int G_ADDR_WIDTH = 10,
    parameter int G_DATA_WIDTH = 8
);
    logic [G_ADDR_WIDTH-1:0] mem_adr;
    logic                    mem_rd;
    logic [G_DATA_WIDTH-1:0] mem_dat;
    logic                    tvalid;
    logic                    tready;
    logic [G_DATA_WIDTH-1:0] tdata;
    logic                    tlast;

    modport master (
        output mem_adr, mem_rd, tvalid, tdata, tlast,
        input  mem_dat, tready
    );

    modport slave (
        input  mem_adr, mem_rd, tvalid, tdata, tlast,
        output mem_dat, tready
    );
endinterface

// File: rtl/mem_port_b_fifo.sv
// Show-ahead FIFO; head entry is driven straight from storage flops.
module mem_port_b_fifo
    import mem_port_b_streamer_pkg::*;
#(
    parameter int G_WIDTH = 9,
    parameter int G_DEPTH = C_FIFO_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [G_WIDTH-1:0]               push_data,
    input  logic                             pop,
    output logic [G_WIDTH-1:0]               pop_data,
    output logic [fifo_cnt_w(G_DEPTH)-1:0]   count,
    output logic                             empty,
    output logic                             full
);
    localparam int PTR_W = $clog2(G_DEPTH);
    localparam int CNT_W = fifo_cnt_w(G_DEPTH);

    logic [G_WIDTH-1:0] mem_q [G_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_pop;

    assign do_pop   = pop && !empty;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(G_DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < G_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/mem_port_b_streamer.sv
// Reads a programmed RAM window on port B and emits it as a byte stream,
// one-shot or looping, with credit-based issue so the output FIFO never overflows.
module mem_port_b_streamer
    import mem_port_b_streamer_pkg::*;
#(
    parameter int G_ADDR_WIDTH = 10,
    parameter int G_DATA_WIDTH = 8,
    parameter int G_FIFO_DEPTH = C_FIFO_DEPTH_DEF
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic [G_ADDR_WIDTH-1:0] base_i,
    input  logic [G_ADDR_WIDTH:0]   len_i,
    input  logic                    loop_i,
    output logic                    busy_o,
    output logic                    done_o,
    mem_port_b_streamer_if.master   bus
);
    localparam int LEN_W = G_ADDR_WIDTH + 1;
    localparam int CNT_W = fifo_cnt_w(G_FIFO_DEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    stream_state_t           state_q, state_d;
    logic [LEN_W-1:0]        idx_q, idx_d;
    logic [G_ADDR_WIDTH-1:0] base_q;
    logic [LEN_W-1:0]        len_q;
    logic                    loop_q;
    logic                    zero_done_q;
    logic                    vld_p1;
    logic                    last_p1;

    logic                    accept_run, accept_zero;
    logic                    issue, is_last, pop, drained, credit_ok;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty, fifo_full;
    logic [G_DATA_WIDTH:0]   fifo_dout;
    logic [CNT_W:0]          occ_after;

    assign accept_run  = (state_q == ST_IDLE) && start_i && (len_i != '0);
    assign accept_zero = (state_q == ST_IDLE) && start_i && (len_i == '0);
    assign is_last     = (idx_q == len_q - LEN_ONE);
    assign pop         = bus.tvalid && bus.tready;

    // Words committed after this cycle: buffered + in flight - popped.
    assign occ_after = {1'b0, fifo_count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
    assign credit_ok = (occ_after < (CNT_W+1)'(G_FIFO_DEPTH));
    assign issue     = (state_q == ST_RUN) && credit_ok;
    assign drained   = (state_q == ST_DRAIN) && fifo_empty && !vld_p1;

    assign bus.mem_rd  = issue;
    assign bus.mem_adr = base_q + idx_q[G_ADDR_WIDTH-1:0];
    assign bus.tvalid  = !fifo_empty;
    assign bus.tdata   = fifo_dout[G_DATA_WIDTH-1:0];
    assign bus.tlast   = fifo_dout[G_DATA_WIDTH];
    assign done_o      = drained || zero_done_q;
    assign busy_o      = (state_q != ST_IDLE) && !drained;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_run) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    if (!is_last)   idx_d = idx_q + LEN_ONE;
                    else if (loop_q) idx_d = '0;
                    else             state_d = ST_DRAIN;
                end
                if (stop_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drained) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            base_q      <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            zero_done_q <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            zero_done_q <= accept_zero;
            vld_p1      <= issue;
            if (accept_run) begin
                base_q <= base_i;
                len_q  <= len_i;
                loop_q <= loop_i;
            end
        end
    end

    // p1: RAM data returns; last tag follows its read.
    always_ff @(posedge aclk) begin
        last_p1 <= is_last;
    end

    mem_port_b_fifo #(
        .G_WIDTH (G_DATA_WIDTH + 1),
        .G_DEPTH (G_FIFO_DEPTH)
    ) u_fifo (
        .clk       (aclk),
        .rst       (areset),
        .push      (vld_p1 && !fifo_full),
        .push_data ({last_p1, bus.mem_dat}),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_mem_port_b_streamer.sv
// Directed bench for mem_port_b_streamer with a behavioural port-B RAM.
module tb_mem_port_b_streamer;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int FD = 2;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          loop_i = 1'b0;
    logic [AW-1:0] base_i = '0;
    logic [AW:0]   len_i = '0;
    logic          busy_o, done_o;

    mem_port_b_streamer_if #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW)) bus ();

    mem_port_b_streamer #(
        .G_ADDR_WIDTH (AW),
        .G_DATA_WIDTH (DW),
        .G_FIFO_DEPTH (FD)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .start_i (start_i),
        .stop_i  (stop_i),
        .base_i  (base_i),
        .len_i   (len_i),
        .loop_i  (loop_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    logic [DW-1:0] ram [2**AW];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    logic [DW:0]   pop_q[$];
    int            pop_cyc[$];
    logic [AW-1:0] adr_q[$];
    int            rd_cyc[$];
    int            done_cyc[$];
    int            outst = 0;
    int            max_out = 0;
    bit            busy_seen = 0;
    bit            prev_stall = 0;
    logic [DW:0]   prev_word = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    initial forever begin
        @(posedge aclk);
        cyc <= cyc + 1;
        if (bus.mem_rd) bus.mem_dat <= ram[bus.mem_adr];
    end

    // Observer: samples everything mid-cycle on the falling edge.
    initial forever begin
        @(negedge aclk);
        if (areset) begin
            outst      = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 32'({bus.tvalid, bus.tlast, bus.tdata}), 32'({1'b1, prev_word}));
            if (bus.mem_rd) begin
                adr_q.push_back(bus.mem_adr);
                rd_cyc.push_back(cyc);
                outst++;
            end
            if (bus.tvalid && bus.tready) begin
                pop_q.push_back({bus.tlast, bus.tdata});
                pop_cyc.push_back(cyc);
                outst--;
            end
            if (outst > max_out) max_out = outst;
            if (busy_o) busy_seen = 1;
            if (done_o) begin
                done_cyc.push_back(cyc);
                chk("done_busy", 32'(busy_o), 32'd0);
            end
            prev_stall = bus.tvalid && !bus.tready;
            prev_word  = {bus.tlast, bus.tdata};
        end
    end

    task automatic clr();
        pop_q.delete(); pop_cyc.delete(); adr_q.delete(); rd_cyc.delete(); done_cyc.delete();
        max_out   = 0;
        busy_seen = 0;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l, input logic lp, output int c0);
        @(posedge aclk); #1;
        base_i = b; len_i = l; loop_i = lp; start_i = 1'b1;
        c0 = cyc;
        @(posedge aclk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit toggle, input int max_cyc);
        bit got = 0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(posedge aclk); #1;
            bus.tready = toggle ? ~bus.tready : 1'b1;
            @(negedge aclk);
            if (done_o) got = 1;
        end
        chk({tag, "_done"}, 32'(got), 32'd1);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    initial begin
        int c0;
        bit got;
        logic [AW-1:0] a;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bit got;
        logic [AW-1:0] a;
        bus.tready  = 1'b1;
        bus.mem_dat = '0;
        for (int i = 0; i < 2**AW; i++) ram[i] = DW'(i * 7 + 3);
        for (int i = 0; i < 4; i++) ram[16 + i] = DW'(8'hA0 + i);

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_rd", 32'(bus.mem_rd), 0);
        chk("rst_vld", 32'(bus.tvalid), 0);
        chk("rst_last", 32'(bus.tlast), 0);
        chk("rst_adr", 32'(bus.mem_adr), 0);
        chk("rst_data", 32'(bus.tdata), 0);
        @(posedge aclk); #1;
        areset = 1'b0;

        // One-shot
        clr();
        do_start(10'h010, 11'd4, 1'b0, c0);
        wait_done("os", 1'b0, 50);
        chk("os_n", 32'(pop_q.size()), 4);
        for (int i = 0; i < pop_q.size() && i < 4; i++)
            chk("os_word", 32'(pop_q[i]), (i == 3 ? 32'h100 : 32'h0) | 32'(8'hA0 + i));
        chk("os_rd_n", 32'(rd_cyc.size()), 4);
        chk("os_rd_lat", 32'(rd_cyc[0] - c0), 1);
        chk("os_vld_lat", 32'(pop_cyc[0] - c0), 3);
        chk("os_b2b", 32'(pop_cyc[3] - pop_cyc[0]), 3);
        chk("os_done_n", 32'(done_cyc.size()), 1);
        chk("os_done_t", 32'(done_cyc[0] - pop_cyc[3]), 1);
        chk("os_busy", 32'(busy_o), 0);

        // Address wrap
        clr();
        do_start(10'h3FE, 11'd4, 1'b0, c0);
        wait_done("wr", 1'b0, 50);
        chk("wr_n", 32'(pop_q.size()), 4);
        for (int i = 0; i < pop_q.size() && i < 4; i++) begin
            a = AW'(10'h3FE + i);
            chk("wr_adr", 32'(adr_q[i]), 32'(a));
            chk("wr_word", 32'(pop_q[i]), 32'({i == 3, ram[a]}));
        end

        // Backpressure
        clr();
        do_start(10'h100, 11'd8, 1'b0, c0);
        wait_done("bp", 1'b1, 100);
        bus.tready = 1'b1;
        chk("bp_n", 32'(pop_q.size()), 8);
        for (int i = 0; i < pop_q.size() && i < 8; i++)
            chk("bp_word", 32'(pop_q[i]), 32'({i == 7, ram[10'h100 + i]}));
        chk("bp_occ_le_depth", 32'(max_out <= FD), 1);

        // Loop and stop
        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33;
        clr();
        do_start(10'h000, 11'd3, 1'b1, c0);
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge aclk); #1;
            if (pop_q.size() >= 7) begin
                stop_i = 1'b1;
                got    = 1;
            end
        end
        chk("ls_stop_reached", 32'(got), 1);
        @(posedge aclk); #1;
        stop_i = 1'b0;
        wait_done("ls", 1'b0, 50);
        chk("ls_n", 32'(pop_q.size()), 10);
        for (int i = 0; i < pop_q.size() && i < 10; i++)
            chk("ls_word", 32'(pop_q[i]), 32'({(i % 3) == 2, ram[i % 3]}));
        chk("ls_rd_n", 32'(rd_cyc.size()), 10);
        chk("ls_no_rd_after", 32'(rd_cyc[rd_cyc.size() - 1] < done_cyc[0]), 1);
        chk("ls_done_n", 32'(done_cyc.size()), 1);

        // Zero-length start
        clr();
        do_start(10'h055, 11'd0, 1'b0, c0);
        repeat (4) @(posedge aclk);
        #1;
        chk("z_done_n", 32'(done_cyc.size()), 1);
        chk("z_done_t", 32'(done_cyc[0] - c0), 1);
        chk("z_rd_n", 32'(rd_cyc.size()), 0);
        chk("z_pop_n", 32'(pop_q.size()), 0);
        chk("z_busy", 32'(busy_seen), 0);

        // Start while busy is ignored
        bus.tready = 1'b0;
        clr();
        do_start(10'h020, 11'd4, 1'b0, c0);
        repeat (3) @(posedge aclk);
        #1;
        do_start(10'h040, 11'd2, 1'b1, c0);
        wait_done("sb", 1'b0, 60);
        chk("sb_n", 32'(pop_q.size()), 4);
        for (int i = 0; i < pop_q.size() && i < 4; i++) begin
            chk("sb_adr", 32'(adr_q[i]), 32'(10'h020 + i));
            chk("sb_word", 32'(pop_q[i]), 32'({i == 3, ram[10'h020 + i]}));
        end
        chk("sb_done_n", 32'(done_cyc.size()), 1);

        // Reset mid-run with two words buffered
        bus.tready = 1'b0;
        clr();
        do_start(10'h030, 11'd6, 1'b0, c0);
        repeat (6) @(posedge aclk);
        #1;
        chk("rs_pre_vld", 32'(bus.tvalid), 1);
        chk("rs_pre_busy", 32'(busy_o), 1);
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("rs_vld", 32'(bus.tvalid), 0);
        chk("rs_busy", 32'(busy_o), 0);
        chk("rs_rd", 32'(bus.mem_rd), 0);
        repeat (5) @(posedge aclk);
        #1;
        chk("rs_no_done", 32'(done_cyc.size()), 0);
        chk("rs_no_pop", 32'(pop_q.size()), 0);
        bus.tready = 1'b1;
        clr();
        do_start(10'h030, 11'd2, 1'b0, c0);
        wait_done("rs2", 1'b0, 50);
        chk("rs2_n", 32'(pop_q.size()), 2);
        for (int i = 0; i < pop_q.size() && i < 2; i++)
            chk("rs2_word", 32'(pop_q[i]), 32'({i == 1, ram[10'h030 + i]}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
